line_capture_buffer: RTL and testbench

- Consumes the HSYNC-qualified raw pixel stream from the image source/sensor front end.
- Stores each complete line in a ping-pong line buffer.
- Re-emits lines as a valid/ready stream with line and frame markers toward the SPIHT wavelet stage.
- Decouples the bursty, gap-separated camera timing from downstream back-pressure and flags malformed or dropped lines.

---
 rtl/line_capture_buffer_pkg.sv | 14 +
 rtl/line_capture_buffer_if.sv | 29 ++
 rtl/line_buf_dpram.sv | 30 +++
 rtl/line_capture_buffer.sv | 226 ++++++++++++++++++++++
 tb/tb_line_capture_buffer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_capture_buffer_pkg.sv
// Shared defaults and read-side state encoding for the line capture buffer.
package line_capture_buffer_pkg;

  localparam int LCB_IMG_WIDTH  = 256;
  localparam int LCB_IMG_HEIGHT = 256;
  localparam int LCB_DATA_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PRIME  = 2'b01,
    ST_STREAM = 2'b10
  } rd_state_t;

endpackage

// File: rtl/line_capture_buffer_if.sv
// Output pixel stream toward the wavelet stage: valid/ready with line/frame markers.
// LINE_SUM exists only when LINE_CHKSUM_EN is defined.
interface line_capture_buffer_if
  import line_capture_buffer_pkg::*;
#(
  parameter int DATA_W = LCB_DATA_W
) ();

  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_SOL;
  logic              OUT_EOL;
  logic              OUT_EOF;
`ifdef LINE_CHKSUM_EN
  logic [DATA_W-1:0] LINE_SUM;

  modport master (output OUT_VALID, OUT_DATA, OUT_SOL, OUT_EOL, OUT_EOF, LINE_SUM,
                  input  OUT_READY);
  modport slave  (input  OUT_VALID, OUT_DATA, OUT_SOL, OUT_EOL, OUT_EOF, LINE_SUM,
                  output OUT_READY);
`else
  modport master (output OUT_VALID, OUT_DATA, OUT_SOL, OUT_EOL, OUT_EOF,
                  input  OUT_READY);
  modport slave  (input  OUT_VALID, OUT_DATA, OUT_SOL, OUT_EOL, OUT_EOF,
                  output OUT_READY);
`endif

endinterface

// File: rtl/line_buf_dpram.sv
// Ping-pong line storage: 2*2^AW words, address MSB selects the buffer.
// One write port, one registered read port with 1-cycle latency.
module line_buf_dpram #(
  parameter int AW     = 8,
  parameter int DATA_W = 16
) (
  input  logic              PCLK,
  input  logic              RST,
  input  logic              we,
  input  logic [AW:0]       waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW:0]       raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**(AW+1)];

  // Pixel write port
  always_ff @(posedge PCLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; output holds while re is low so stalled beats stay stable
  always_ff @(posedge PCLK or negedge RST) begin
    if (!RST)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_capture_buffer.sv
// Line capture buffer: captures HSYNC-qualified lines into a ping-pong buffer
// and replays them as a valid/ready stream with SOL/EOL/EOF markers.
// Optional macro LINE_CHKSUM_EN adds a per-line modulo-2^DATA_W pixel sum (LINE_SUM).
module line_capture_buffer
  import line_capture_buffer_pkg::*;
#(
  parameter int IMG_WIDTH  = LCB_IMG_WIDTH,
  parameter int IMG_HEIGHT = LCB_IMG_HEIGHT,
  parameter int DATA_W     = LCB_DATA_W
) (
  input  logic                  PCLK,
  input  logic                  RST,
  input  logic                  HSYNC,
  input  logic [DATA_W-1:0]     Pixel_DATA,
  input  logic                  CLR_ERR,
  output logic                  FRAME_DONE,
  output logic                  LINE_ERR,
  output logic                  OVERFLOW,
  line_capture_buffer_if.master stream
);

  localparam int AW  = $clog2(IMG_WIDTH);
  localparam int LCW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [AW:0]    FULL_CNT    = (AW+1)'(IMG_WIDTH);
  localparam logic [AW-1:0]  LAST_BEAT   = AW'(IMG_WIDTH - 1);
  localparam logic [AW-1:0]  PENULT_BEAT = AW'(IMG_WIDTH - 2);
  localparam logic [LCW-1:0] LAST_LINE   = LCW'(IMG_HEIGHT - 1);

  // Write side
  logic           hsync_q, wr_active, wr_ptr;
  logic [AW:0]    wr_cnt;
  logic [LCW-1:0] line_cnt;
  logic [1:0]     buf_full, buf_eof;
  logic           line_start, line_end, commit, ovf_set, lerr_set;
  logic           ram_we;
  logic [AW:0]    ram_waddr;

  // Read side
  rd_state_t         rd_state;
  logic              rd_ptr, out_valid, out_sol, out_eol, out_eof, frame_done_q;
  logic [AW-1:0]     beat, beat_nxt;
  logic              rd_accept, beat_last, rd_release, ram_re;
  logic [AW:0]       ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic              line_err_q, overflow_q;

  assign line_start = HSYNC & ~hsync_q;
  assign line_end   = ~HSYNC & hsync_q;

  // Per-pixel write decode and line-end verdict
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = {wr_ptr, {AW{1'b0}}};
    ovf_set   = 1'b0;
    lerr_set  = 1'b0;
    commit    = 1'b0;
    if (line_start) begin
      if (buf_full[wr_ptr]) ovf_set = 1'b1;
      else                  ram_we  = 1'b1;
    end else if (HSYNC && wr_active) begin
      if (wr_cnt < FULL_CNT) begin
        ram_we    = 1'b1;
        ram_waddr = {wr_ptr, wr_cnt[AW-1:0]};
      end else begin
        lerr_set = 1'b1;
      end
    end
    // wr_cnt saturates at IMG_WIDTH, so long lines also land on the commit branch
    if (line_end && wr_active) begin
      if (wr_cnt == FULL_CNT) commit   = 1'b1;
      else                    lerr_set = 1'b1;
    end
  end

  // Write pointer, pixel count, line counter and buffer ownership flags
  always_ff @(posedge PCLK or negedge RST) begin
    if (!RST) begin
      hsync_q   <= 1'b0;
      wr_active <= 1'b0;
      wr_cnt    <= '0;
      wr_ptr    <= 1'b0;
      line_cnt  <= '0;
      buf_full  <= '0;
      buf_eof   <= '0;
    end else begin
      hsync_q <= HSYNC;
      if (line_start) begin
        wr_active <= ~buf_full[wr_ptr];
        wr_cnt    <= {{AW{1'b0}}, 1'b1};
      end else if (ram_we) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (line_end) wr_active <= 1'b0;
      if (commit) begin
        buf_full[wr_ptr] <= 1'b1;
        buf_eof[wr_ptr]  <= (line_cnt == LAST_LINE);
        wr_ptr           <= ~wr_ptr;
        line_cnt         <= (line_cnt == LAST_LINE) ? '0 : line_cnt + 1'b1;
      end
      // Release always targets the read buffer, which is never the one being committed
      if (rd_release) buf_full[rd_ptr] <= 1'b0;
    end
  end

  // Sticky error flags; a same-cycle set beats CLR_ERR
  always_ff @(posedge PCLK or negedge RST) begin
    if (!RST) begin
      line_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (lerr_set)     line_err_q <= 1'b1;
      else if (CLR_ERR) line_err_q <= 1'b0;
      if (ovf_set)      overflow_q <= 1'b1;
      else if (CLR_ERR) overflow_q <= 1'b0;
    end
  end

  assign rd_accept  = out_valid & stream.OUT_READY;
  assign beat_last  = (beat == LAST_BEAT);
  assign rd_release = rd_accept & beat_last;
  assign beat_nxt   = beat + 1'b1;

  // Read address: word 0 while priming, next word on each accepted non-final beat
  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = {rd_ptr, {AW{1'b0}}};
    if (rd_state == ST_PRIME) begin
      ram_re = 1'b1;
    end else if (rd_accept && !beat_last) begin
      ram_re    = 1'b1;
      ram_raddr = {rd_ptr, beat_nxt};
    end
  end

  // Read FSM with registered stream markers and FRAME_DONE pulse
  always_ff @(posedge PCLK or negedge RST) begin
    if (!RST) begin
      rd_state     <= ST_IDLE;
      rd_ptr       <= 1'b0;
      beat         <= '0;
      out_valid    <= 1'b0;
      out_sol      <= 1'b0;
      out_eol      <= 1'b0;
      out_eof      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (rd_state)
        ST_IDLE: begin
          if (buf_full[rd_ptr]) rd_state <= ST_PRIME;
        end
        ST_PRIME: begin
          rd_state  <= ST_STREAM;
          beat      <= '0;
          out_valid <= 1'b1;
          out_sol   <= 1'b1;
          out_eol   <= 1'b0;
          out_eof   <= 1'b0;
        end
        ST_STREAM: begin
          if (rd_accept) begin
            if (beat_last) begin
              out_valid    <= 1'b0;
              out_sol      <= 1'b0;
              out_eol      <= 1'b0;
              out_eof      <= 1'b0;
              frame_done_q <= out_eof;
              rd_ptr       <= ~rd_ptr;
              rd_state     <= buf_full[~rd_ptr] ? ST_PRIME : ST_IDLE;
            end else begin
              beat    <= beat_nxt;
              out_sol <= 1'b0;
              out_eol <= (beat == PENULT_BEAT);
              out_eof <= (beat == PENULT_BEAT) & buf_eof[rd_ptr];
            end
          end
        end
        default: rd_state <= ST_IDLE;
      endcase
    end
  end

`ifdef LINE_CHKSUM_EN
  logic [DATA_W-1:0] wr_sum;
  logic [DATA_W-1:0] buf_sum [2];

  // Running sum of stored pixels, latched per buffer at commit
  always_ff @(posedge PCLK or negedge RST) begin
    if (!RST) begin
      wr_sum     <= '0;
      buf_sum[0] <= '0;
      buf_sum[1] <= '0;
    end else begin
      if (line_start)  wr_sum <= Pixel_DATA;
      else if (ram_we) wr_sum <= wr_sum + Pixel_DATA;
      if (commit) buf_sum[wr_ptr] <= wr_sum;
    end
  end

  assign stream.LINE_SUM = out_eol ? buf_sum[rd_ptr] : '0;
`endif

  line_buf_dpram #(
    .AW     (AW),
    .DATA_W (DATA_W)
  ) u_ram (
    .PCLK  (PCLK),
    .RST   (RST),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (Pixel_DATA),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign stream.OUT_VALID = out_valid;
  assign stream.OUT_DATA  = ram_rdata;
  assign stream.OUT_SOL   = out_sol;
  assign stream.OUT_EOL   = out_eol;
  assign stream.OUT_EOF   = out_eof;
  assign FRAME_DONE       = frame_done_q;
  assign LINE_ERR         = line_err_q;
  assign OVERFLOW         = overflow_q;

endmodule

// File: tb/tb_line_capture_buffer.sv
// Bench for line_capture_buffer at IMG_WIDTH=8, IMG_HEIGHT=4: table of lines plus
// hand-written overflow and mid-stream reset sequences, checked via a beat scoreboard.
module tb_line_capture_buffer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 16;
  localparam int GAP = 30;

  logic          PCLK = 1'b0;
  logic          RST = 1'b0;
  logic          HSYNC = 1'b0;
  logic [DW-1:0] Pixel_DATA = '0;
  logic          CLR_ERR = 1'b0;
  logic          FRAME_DONE, LINE_ERR, OVERFLOW;

  line_capture_buffer_if #(.DATA_W(DW)) stream ();

  line_capture_buffer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_W     (DW)
  ) dut (
    .PCLK       (PCLK),
    .RST        (RST),
    .HSYNC      (HSYNC),
    .Pixel_DATA (Pixel_DATA),
    .CLR_ERR    (CLR_ERR),
    .FRAME_DONE (FRAME_DONE),
    .LINE_ERR   (LINE_ERR),
    .OVERFLOW   (OVERFLOW),
    .stream     (stream)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sol;
    logic          eol;
    logic          eof;
    logic [DW-1:0] sum;
  } beat_t;

  typedef struct {
    int            npix;
    logic [DW-1:0] base;
    int            rdy;
    bit            clr;
    bit            exp_err;
  } row_t;

  beat_t         exp_q[$];
  beat_t         mon_e;
  row_t          tbl[13];
  int            checks = 0;
  int            errors = 0;
  int            exp_line = 0;
  int            exp_fd = 0;
  int            fd_cnt = 0;
  int            beats_seen = 0;
  int            rdy_mode = 1;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [3:0]    prev_marks = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready driver: 0 = held low, 1 = held high, 2 = toggling every cycle
  initial begin
    stream.OUT_READY = 1'b0;
    forever begin
      @(posedge PCLK);
      #1;
      if (rdy_mode == 2)      stream.OUT_READY = ~stream.OUT_READY;
      else if (rdy_mode == 1) stream.OUT_READY = 1'b1;
      else                    stream.OUT_READY = 1'b0;
    end
  end

  // Monitor: pop and compare every accepted beat, check stall stability, count FRAME_DONE
  initial begin
    forever begin
      @(negedge PCLK);
      if (RST) begin
        if (stall_prev && stream.OUT_VALID) begin
          check("stall_data", stream.OUT_DATA, prev_data);
          check("stall_marks", {stream.OUT_VALID, stream.OUT_SOL, stream.OUT_EOL, stream.OUT_EOF}, prev_marks);
        end
        if (stream.OUT_VALID && stream.OUT_READY) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", stream.OUT_DATA, 32'hFFFF_FFFF);
          end else begin
            mon_e = exp_q.pop_front();
            check("beat_data", stream.OUT_DATA, mon_e.data);
            check("beat_sol", stream.OUT_SOL, mon_e.sol);
            check("beat_eol", stream.OUT_EOL, mon_e.eol);
            check("beat_eof", stream.OUT_EOF, mon_e.eof);
`ifdef LINE_CHKSUM_EN
            if (mon_e.eol) check("line_sum", stream.LINE_SUM, mon_e.sum);
`endif
            if (mon_e.eof) exp_fd++;
          end
          beats_seen++;
        end
        stall_prev = stream.OUT_VALID && !stream.OUT_READY;
        prev_data  = stream.OUT_DATA;
        prev_marks = {stream.OUT_VALID, stream.OUT_SOL, stream.OUT_EOL, stream.OUT_EOF};
        if (FRAME_DONE) fd_cnt++;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // Drive one HSYNC line; when it should be committed, its beats go onto the scoreboard
  task automatic send_line(input int n, input logic [DW-1:0] base, input bit commit_exp);
    logic [DW-1:0] s;
    s = '0;
    if (commit_exp) begin
      for (int i = 0; i < W; i++) s = s + base + DW'(i);
      for (int i = 0; i < W; i++)
        exp_q.push_back('{data: base + DW'(i), sol: (i == 0), eol: (i == W-1),
                          eof: (i == W-1) && (exp_line == H-1), sum: s});
      exp_line = (exp_line + 1) % H;
    end
    @(posedge PCLK);
    #1;
    for (int i = 0; i < n; i++) begin
      HSYNC      = 1'b1;
      Pixel_DATA = base + DW'(i);
      @(posedge PCLK);
      #1;
    end
    HSYNC      = 1'b0;
    Pixel_DATA = '0;
    repeat (GAP) @(posedge PCLK);
  endtask

  task automatic pulse_clr();
    @(posedge PCLK);
    #1 CLR_ERR = 1'b1;
    @(posedge PCLK);
    #1 CLR_ERR = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || stream.OUT_VALID) && n < max) begin
      @(negedge PCLK);
      n++;
    end
    check("drain_in_time", 32'(n < max), 32'd1);
    check("pending_beats", exp_q.size(), 0);
    repeat (3) @(negedge PCLK);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, stream.OUT_VALID, 0);
    check({tag, "_sol"}, stream.OUT_SOL, 0);
    check({tag, "_eol"}, stream.OUT_EOL, 0);
    check({tag, "_eof"}, stream.OUT_EOF, 0);
    check({tag, "_data"}, stream.OUT_DATA, 0);
    check({tag, "_frame_done"}, FRAME_DONE, 0);
    check({tag, "_line_err"}, LINE_ERR, 0);
    check({tag, "_overflow"}, OVERFLOW, 0);
  endtask

  // Global time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_beats;
    int n;

    tbl = '{
      '{8,  16'h0000, 1, 1'b0, 1'b0},
      '{8,  16'h0008, 1, 1'b0, 1'b0},
      '{8,  16'h0010, 1, 1'b0, 1'b0},
      '{8,  16'h0018, 1, 1'b0, 1'b0},
      '{8,  16'h0000, 2, 1'b0, 1'b0},
      '{8,  16'h0008, 2, 1'b0, 1'b0},
      '{8,  16'h0010, 2, 1'b0, 1'b0},
      '{8,  16'h0018, 2, 1'b0, 1'b0},
      '{6,  16'h0300, 1, 1'b0, 1'b1},
      '{8,  16'h0100, 1, 1'b0, 1'b1},
      '{10, 16'h0200, 1, 1'b0, 1'b1},
      '{8,  16'h0400, 1, 1'b1, 1'b0},
      '{8,  16'h0500, 1, 1'b0, 1'b0}
    };

    repeat (3) @(negedge PCLK);
    check_idle_outputs("reset");
    RST = 1'b1;
    repeat (2) @(negedge PCLK);

    // Table: clean frame, back-pressured frame, short/long line frame
    for (int r = 0; r < 13; r++) begin
      rdy_mode = tbl[r].rdy;
      if (tbl[r].clr) pulse_clr();
      send_line(tbl[r].npix, tbl[r].base, tbl[r].npix >= W);
      check($sformatf("row%0d_line_err", r), LINE_ERR, tbl[r].exp_err);
    end
    rdy_mode = 1;
    wait_drain(200);
    check("frames_done_after_table", fd_cnt, exp_fd);
    check("frames_eof_seen", exp_fd, 3);
    check("table_overflow", OVERFLOW, 0);

    // Overflow: two lines buffered under back-pressure, the third dropped
    rdy_mode = 0;
    send_line(8, 16'h0600, 1'b1);
    send_line(8, 16'h0700, 1'b1);
    send_line(8, 16'h0800, 1'b0);
    @(negedge PCLK);
    check("ovf_set", OVERFLOW, 1);
    check("ovf_stalled_valid", stream.OUT_VALID, 1);
    check("ovf_stalled_data", stream.OUT_DATA, 16'h0600);
    check("ovf_line_err", LINE_ERR, 0);
    rdy_mode = 1;
    wait_drain(200);
    check("ovf_sticky", OVERFLOW, 1);
    pulse_clr();
    @(negedge PCLK);
    check("ovf_cleared", OVERFLOW, 0);

    // Reset in the middle of streaming line 2
    rdy_mode = 0;
    send_line(8, 16'h0900, 1'b1);
    rdy_mode = 1;
    start_beats = beats_seen;
    n = 0;
    while (beats_seen < start_beats + 3 && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    check("midstream_beats_in_time", 32'(n < 100), 32'd1);
    @(posedge PCLK);
    #1 RST = 1'b0;
    exp_q.delete();
    exp_line = 0;
    @(negedge PCLK);
    check_idle_outputs("midreset");
    repeat (2) @(posedge PCLK);
    #1 RST = 1'b1;

    // First line of the new frame: SOL, no stale EOF, pixels 1..8
    send_line(8, 16'h0001, 1'b1);
    wait_drain(200);
    check("final_frame_done", fd_cnt, exp_fd);
    check("final_line_err", LINE_ERR, 0);
    check("final_overflow", OVERFLOW, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
